comb_vec_gen: RTL
=================

COMB_VEC_GEN -- requirements
Module: comb_vec_gen

Interface
REQ-001 Parameter HOLD_CYC, default 10, clocks each vector is held before the response is sampled; legal range is 1..255.
REQ-002 Parameter NUM_VEC, default 32, number of vectors per pass; legal range is 1..32.
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle request to begin a pass.
REQ-006 Port stop  input  1  abort request for the pass in progress.
REQ-007 Port ack  input  1  acknowledges done.
REQ-008 Port y_in  input  1  response from the downstream mux (y).
REQ-009 Port vec_out  output  5  registered stimulus {sel,a,b,c,d}, with sel as the MSB.
REQ-010 Port vec_idx  output  5  index of the vector currently driven.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  high while in DONE.
REQ-013 Port resp  output  32  captured responses, where bit k holds y_in for vector k.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE:
- busy=0, done=0, vec_out=0, vec_idx=0, hold counter=0.
- start=1 -> RUN on the next edge; resp is cleared to 0 on the same edge.
REQ-016 RUN, hold counter:
- counts 0..HOLD_CYC-1 while vec_out=vec_idx.
- at count HOLD_CYC-1, resp[vec_idx] is loaded with y_in, vec_idx and vec_out increment, and the counter returns to 0.
REQ-017 The response is sampled in the last hold cycle only, giving the mux HOLD_CYC-1 cycles to settle.
REQ-018 RUN, last vector: when the hold completes at vec_idx=NUM_VEC-1, the block SHALL go to DONE with vec_out and vec_idx held at their last value.
REQ-019 RUN, start: start SHALL be ignored.
REQ-020 RUN, stop: stop=1 -> IDLE on the next edge.
- vec_out and vec_idx are forced to 0.
- resp keeps the bits captured so far.
- stop has priority over a hold completion in the same cycle, so no capture occurs.
REQ-021 DONE:
- done=1 until ack=1, then IDLE on the next edge.
- start and stop are ignored; start and ack together gives IDLE only.
REQ-022 resp bits at index NUM_VEC and above SHALL read 0.
REQ-023 vec_idx SHALL never exceed NUM_VEC-1.

Reset
REQ-024 Asserting rst_n=0 SHALL force, immediately and asynchronously: IDLE state, all outputs to 0, hold counter to 0.
REQ-025 Reset mid-pass SHALL discard the pass; no partial resp is retained.
REQ-026 After deassertion, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro COMB_VEC_LOOP_EN, defined:
- completing vector NUM_VEC-1 wraps vec_idx and vec_out to 0 and stays in RUN.
- resp is overwritten in place on each pass.
- only stop or reset leaves RUN; done never asserts.
REQ-028 Macro COMB_VEC_LOOP_EN, undefined: single pass, behaviour per REQ-018.

Structure
REQ-029 Package comb_vec_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE).
- VEC_W=5.
- RESP_W=32.
REQ-030 Sub-module comb_vec_hold_tmr SHALL implement the hold counter.
- inputs: clk, rst_n, clr, en.
- output: expire, high when the count equals HOLD_CYC-1.
REQ-031 The FSM, vector counter and resp register SHALL live in comb_vec_gen.

Verification
REQ-032 HOLD_CYC=2, NUM_VEC=32, y_in tied to vec_out[4], start pulse -> vec_out steps 0..31 with 2 cycles per value; done rises 64 cycles after busy rises; resp=32'hFFFF0000.
REQ-033 As REQ-032 with y_in=vec_out[0] -> resp=32'hAAAAAAAA; ack -> IDLE next cycle; vec_out=0.
REQ-034 stop asserted while vec_idx=5 -> busy=0 and vec_out=0 next cycle; resp holds only bits 0..4, with bits 5..31 at 0.
REQ-035 rst_n pulsed low at vec_idx=10 -> outputs 0 without a clock edge; a new start produces vec_out=0 on the next edge.
REQ-036 COMB_VEC_LOOP_EN, HOLD_CYC=1, NUM_VEC=4 -> vec_out sequence 0,1,2,3,0,1...; done stays 0; stop returns the block to IDLE.
REQ-037 Start, ack and stop driven simultaneously in DONE -> IDLE next cycle, with busy remaining 0.

Source files
------------

// File: rtl/comb_vec_pkg.sv
// rtl/comb_vec_pkg.sv - shared widths and FSM state type for the combinational-mux vector generator
package comb_vec_pkg;

    localparam int VEC_W  = 5;
    localparam int RESP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comb_vec_hold_tmr.sv
// rtl/comb_vec_hold_tmr.sv - per-vector hold counter, expire flags the final hold cycle
module comb_vec_hold_tmr #(
    parameter int HOLD_CYC = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] TOP = 8'(HOLD_CYC - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? 8'd0 : cnt + 8'd1;
        end
    end

    assign expire = (cnt == TOP);

endmodule

// File: rtl/comb_vec_gen.sv
// rtl/comb_vec_gen.sv - exhaustive 5-bit stimulus generator with response capture; COMB_VEC_LOOP_EN selects continuous looping
module comb_vec_gen
    import comb_vec_pkg::*;
#(
    parameter int HOLD_CYC = 10,
    parameter int NUM_VEC  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              ack,
    input  logic              y_in,
    output logic [VEC_W-1:0]  vec_out,
    output logic [VEC_W-1:0]  vec_idx,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] resp
);

    localparam logic [VEC_W-1:0]  LAST      = VEC_W'(NUM_VEC - 1);
    localparam logic [RESP_W-1:0] RESP_MASK = RESP_W'((33'd1 << NUM_VEC) - 33'd1);

    state_t             state, next_state;
    logic [VEC_W-1:0]   vec_q;
    logic [RESP_W-1:0]  resp_q;
    logic               expire;
    logic               tmr_clr;
    logic               tmr_en;
    logic               capture;
    logic               vec_zero;
    logic               vec_inc;
    logic               resp_clr;

    comb_vec_hold_tmr #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tmr_clr    = 1'b1;
        tmr_en     = 1'b0;
        capture    = 1'b0;
        vec_zero   = 1'b0;
        vec_inc    = 1'b0;
        resp_clr   = 1'b0;
        case (state)
            IDLE: begin
                vec_zero = 1'b1;
                if (start) begin
                    next_state = RUN;
                    resp_clr   = 1'b1;
                end
            end
            RUN: begin
                // stop wins over a completing hold, so the pending capture is dropped
                if (stop) begin
                    next_state = IDLE;
                    vec_zero   = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                    if (expire) begin
                        capture = 1'b1;
                        if (vec_q == LAST) begin
`ifdef COMB_VEC_LOOP_EN
                            vec_zero = 1'b1;
`else
                            next_state = DONE;
`endif
                        end else begin
                            vec_inc = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    next_state = IDLE;
                    vec_zero   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                vec_zero   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (vec_zero) begin
            vec_q <= '0;
        end else if (vec_inc) begin
            vec_q <= vec_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else if (resp_clr) begin
            resp_q <= '0;
        end else if (capture) begin
            resp_q[vec_q] <= y_in;
        end
    end

    // the stimulus register doubles as the index: they are equal in every state
    assign vec_out = vec_q;
    assign vec_idx = vec_q;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign resp    = resp_q & RESP_MASK;

endmodule
